// File: rtl/dvp_tx_pkg.sv
// ============================================================================
// Module      : dvp_tx_pkg
// Description : Shared types and constants for the DVP RGB565 pattern transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dvp_tx_pkg;

    typedef enum logic [1:0] {
        PAT_BARS     = 2'd0,
        PAT_GRADIENT = 2'd1,
        PAT_SOLID    = 2'd2,
        PAT_CHECKER  = 2'd3
    } pattern_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tx_state_e;

    localparam logic [15:0] c_BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] c_BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] c_BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] c_BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] c_BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] c_BAR_RED     = 16'hF800;
    localparam logic [15:0] c_BAR_BLUE    = 16'h001F;
    localparam logic [15:0] c_BAR_BLACK   = 16'h0000;

    localparam logic [15:0] c_CRC_POLY = 16'h1021;
    localparam logic [15:0] c_CRC_INIT = 16'hFFFF;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return c_BAR_WHITE;
            3'd1:    return c_BAR_YELLOW;
            3'd2:    return c_BAR_CYAN;
            3'd3:    return c_BAR_GREEN;
            3'd4:    return c_BAR_MAGENTA;
            3'd5:    return c_BAR_RED;
            3'd6:    return c_BAR_BLUE;
            default: return c_BAR_BLACK;
        endcase
    endfunction

    // CRC-16-CCITT, one byte, MSB first
    function automatic logic [15:0] crc16_ccitt_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ c_CRC_POLY;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dvp_pattern_gen.sv
// ============================================================================
// Module      : dvp_pattern_gen
// Description : RGB565 test-pattern pixel generator (bars, gradient, solid, checker).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dvp_pattern_gen
    import dvp_tx_pkg::*;
#(
    parameter int H_ACTIVE = 640
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_step,
    input  logic [15:0] i_x,
    input  logic [15:0] i_y,
    input  pattern_e    i_pattern,
    input  logic [15:0] i_solid,
    input  logic        i_frame_lsb,
    output logic [15:0] o_pixel
);

    localparam int BAR_W = H_ACTIVE / 8;
    localparam int CW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [CW-1:0] c_BAR_LAST = CW'(BAR_W - 1);

    logic [CW-1:0] r_bar_cnt;
    logic [2:0]    r_bar_idx;

    // Bar index tracks the current x; stepping past the active width only wraps in blanking.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_bar_cnt <= '0;
            r_bar_idx <= '0;
        end else if (i_step) begin
            if (r_bar_cnt == c_BAR_LAST) begin
                r_bar_cnt <= '0;
                r_bar_idx <= r_bar_idx + 3'd1;
            end else begin
                r_bar_cnt <= r_bar_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        o_pixel = 16'h0000;
        case (i_pattern)
            PAT_BARS:     o_pixel = bar_color(r_bar_idx);
            PAT_GRADIENT: o_pixel = i_x + (i_y << 5);
            PAT_SOLID:    o_pixel = i_solid;
            PAT_CHECKER:  o_pixel = (i_x[4] ^ i_y[4] ^ i_frame_lsb) ? 16'hFFFF : 16'h0000;
            default:      o_pixel = 16'h0000;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dvp_pattern_tx.sv
// ============================================================================
// Module      : dvp_pattern_tx
// Description : OV5640-style 8-bit DVP transmitter streaming RGB565 test patterns.
//               Optional frame CRC enabled by defining DVP_TX_CRC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dvp_pattern_tx
    import dvp_tx_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_ACTIVE    = 480,
    parameter int V_TOTAL     = 525,
    parameter int VSYNC_LINES = 2,
    parameter int V_START     = 4
)(
    input  logic        xclk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_color,
    output logic        cam_pclk,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_data,
    output logic        frame_done,
    output logic [15:0] frame_cnt
`ifdef DVP_TX_CRC_EN
    ,
    output logic [15:0] frame_crc
`endif
);

    localparam int XW = $clog2(2 * H_TOTAL);
    localparam int YW = $clog2(V_TOTAL);

    localparam logic [XW-1:0] c_X_LAST   = XW'(2 * H_TOTAL - 1);
    localparam logic [XW-1:0] c_X_ACTIVE = XW'(2 * H_ACTIVE);
    localparam logic [YW-1:0] c_Y_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] c_Y_VSYNC  = YW'(VSYNC_LINES);
    localparam logic [YW:0]   c_Y_START  = (YW+1)'(V_START);
    localparam logic [YW:0]   c_Y_END    = (YW+1)'(V_START + V_ACTIVE);

    logic          r_pclk;
    tx_state_e     r_state;
    logic [XW-1:0] r_byte_x;
    logic [YW-1:0] r_line_y;
    pattern_e      r_pattern;
    logic [15:0]   r_solid;

    logic          w_tick;
    logic          w_frame_end;
    logic          w_vsync;
    logic          w_href;
    logic [15:0]   w_x;
    logic [15:0]   w_y;
    logic [15:0]   w_pixel;
    logic [7:0]    w_byte;
    logic          w_gen_clear;
    logic          w_gen_step;

    assign cam_pclk    = r_pclk;
    // Outputs move while pclk is high so they are settled by the next rising pclk edge.
    assign w_tick      = r_pclk;
    assign w_frame_end = (r_byte_x == c_X_LAST) && (r_line_y == c_Y_LAST);
    assign w_vsync     = (r_line_y < c_Y_VSYNC);
    assign w_href      = ({1'b0, r_line_y} >= c_Y_START) && ({1'b0, r_line_y} < c_Y_END)
                         && (r_byte_x < c_X_ACTIVE);
    assign w_x         = 16'(r_byte_x[XW-1:1]);
    assign w_y         = 16'(r_line_y) - 16'(V_START);
    assign w_byte      = w_href ? (r_byte_x[0] ? w_pixel[7:0] : w_pixel[15:8]) : 8'h00;
    assign w_gen_clear = w_tick && ((r_state == ST_IDLE) || (r_byte_x == c_X_LAST));
    assign w_gen_step  = w_tick && (r_state == ST_RUN) && r_byte_x[0];

    dvp_pattern_gen #(
        .H_ACTIVE (H_ACTIVE)
    ) u_gen (
        .clk         (xclk),
        .rst         (rst),
        .i_clear     (w_gen_clear),
        .i_step      (w_gen_step),
        .i_x         (w_x),
        .i_y         (w_y),
        .i_pattern   (r_pattern),
        .i_solid     (r_solid),
        .i_frame_lsb (frame_cnt[0]),
        .o_pixel     (w_pixel)
    );

    always_ff @(posedge xclk) begin
        if (rst) begin
            r_pclk     <= 1'b0;
            r_state    <= ST_IDLE;
            r_byte_x   <= '0;
            r_line_y   <= '0;
            r_pattern  <= PAT_BARS;
            r_solid    <= '0;
            cam_vsync  <= 1'b0;
            cam_href   <= 1'b0;
            cam_data   <= 8'h00;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            r_pclk     <= ~r_pclk;
            frame_done <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    ST_IDLE: begin
                        cam_vsync <= 1'b0;
                        cam_href  <= 1'b0;
                        cam_data  <= 8'h00;
                        if (enable) begin
                            r_state   <= ST_RUN;
                            r_byte_x  <= '0;
                            r_line_y  <= '0;
                            r_pattern <= pattern_e'(pattern_sel);
                            r_solid   <= solid_color;
                        end
                    end
                    ST_RUN: begin
                        cam_vsync <= w_vsync;
                        cam_href  <= w_href;
                        cam_data  <= w_byte;
                        if (w_frame_end) begin
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 16'd1;
                            r_byte_x   <= '0;
                            r_line_y   <= '0;
                            if (enable) begin
                                r_pattern <= pattern_e'(pattern_sel);
                                r_solid   <= solid_color;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else if (r_byte_x == c_X_LAST) begin
                            r_byte_x <= '0;
                            r_line_y <= r_line_y + 1'b1;
                        end else begin
                            r_byte_x <= r_byte_x + 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef DVP_TX_CRC_EN
    logic [15:0] r_crc_acc;
    logic [15:0] w_crc_next;

    assign w_crc_next = w_href ? crc16_ccitt_byte(r_crc_acc, w_byte) : r_crc_acc;

    always_ff @(posedge xclk) begin
        if (rst) begin
            r_crc_acc <= c_CRC_INIT;
            frame_crc <= 16'h0000;
        end else if (w_tick) begin
            if (r_state == ST_IDLE) begin
                r_crc_acc <= c_CRC_INIT;
            end else if (w_frame_end) begin
                frame_crc <= w_crc_next;
                r_crc_acc <= c_CRC_INIT;
            end else begin
                r_crc_acc <= w_crc_next;
            end
        end
    end
`endif

endmodule

`default_nettype wire
